// File: rtl/sym_err_checker.sv
// Symbol error checker: searches for the TX-to-RX symbol delay, locks on it, and
// counts symbol/bit errors per hold window. Bit-error counting: SYM_ERR_CHECKER_BIT_ERR_EN.
module sym_err_checker #(
  parameter int MAX_DELAY   = 63,
  parameter int LOCK_COUNT  = 32,
  parameter int UNLOCK_ERRS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        hold,
  input  logic [1:0]  tx_sym,
  input  logic [1:0]  rx_sym,
  output logic [5:0]  delay_out,
  output logic        locked,
  output logic [15:0] sym_err_cnt,
  output logic [15:0] sym_cnt,
  output logic [16:0] bit_err_cnt,
  output logic        cnt_valid
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int BERR_W = $clog2(UNLOCK_ERRS + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(LOCK_COUNT - 1);
  localparam logic [BERR_W-1:0] UNLOCK_LIM = BERR_W'(UNLOCK_ERRS);
  localparam logic [5:0]        DELAY_LAST = 6'(MAX_DELAY);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_e;

  state_e             state_q;
  logic [5:0]         delay_q;
  logic [RUN_W-1:0]   run_q;
  logic [5:0]         blk_cnt_q;
  logic [BERR_W-1:0]  blk_err_q;
  logic               locked_q;

  logic [1:0]         line_q [1:MAX_DELAY];
  logic [1:0]         ref_sym;
  logic               match;
  logic               mis;
  logic [5:0]         delay_inc;
  logic [BERR_W-1:0]  blk_err_inc;
  logic               latch_now;
  logic               counting;

  logic [15:0]        acc_sym_q, acc_sym_d;
  logic [15:0]        acc_err_q, acc_err_d;
  logic [15:0]        sym_cnt_q;
  logic [15:0]        sym_err_q;
  logic               cnt_valid_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] a, input logic b);
    logic [16:0] s;
    s = {1'b0, a} + {16'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // TX history: line_q[k] holds the symbol from k enabled symbols ago;
  // line[0] is the live tx_sym input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this memory is reset on purpose -- a freshly reset line must read
      // as all-zero symbols, so it cannot be left to power-up contents.
      for (int k = 1; k <= MAX_DELAY; k++) line_q[k] <= '0;
    end else if (clk_en) begin
      line_q[1] <= tx_sym;
      for (int k = 2; k <= MAX_DELAY; k++) line_q[k] <= line_q[k-1];
    end
  end

  always_comb begin
    // NOTE: default assignment first, so no path through this block infers a latch.
    ref_sym = tx_sym;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (delay_q == 6'(k)) ref_sym = line_q[k];
    end
  end

  assign match       = (ref_sym == rx_sym);
  assign mis         = ~match;
  assign delay_inc   = (delay_q == DELAY_LAST) ? 6'd0 : delay_q + 6'd1;
  assign blk_err_inc = blk_err_q + BERR_W'(mis);
  assign latch_now   = clk_en & hold;
  assign counting    = (state_q == ST_LOCKED);

  // Alignment FSM; locked is registered from the same transition as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SEARCH;
      delay_q   <= '0;
      run_q     <= '0;
      blk_cnt_q <= '0;
      blk_err_q <= '0;
      locked_q  <= 1'b0;
    end else if (clk_en) begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      case (state_q)
        ST_SEARCH: begin
          if (match) begin
            state_q <= ST_VERIFY;
            run_q   <= RUN_W'(1);
          end else begin
            delay_q <= delay_inc;
          end
        end
        ST_VERIFY: begin
          if (match) begin
            if (run_q == RUN_LAST) begin
              state_q   <= ST_LOCKED;
              locked_q  <= 1'b1;
              run_q     <= '0;
              blk_cnt_q <= '0;
              blk_err_q <= '0;
            end else begin
              run_q <= run_q + RUN_W'(1);
            end
          end else begin
            state_q <= ST_SEARCH;
            run_q   <= '0;
            delay_q <= delay_inc;
          end
        end
        ST_LOCKED: begin
          if (blk_err_inc >= UNLOCK_LIM) begin
            state_q   <= ST_SEARCH;
            locked_q  <= 1'b0;
            delay_q   <= delay_inc;
            blk_cnt_q <= '0;
            blk_err_q <= '0;
          end else begin
            blk_cnt_q <= blk_cnt_q + 6'd1;
            blk_err_q <= (blk_cnt_q == 6'd63) ? '0 : blk_err_inc;
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // A latching symbol restarts the window and its own compare seeds the new one.
  always_comb begin
    acc_sym_d = latch_now ? 16'd0 : acc_sym_q;
    acc_err_d = latch_now ? 16'd0 : acc_err_q;
    if (counting) begin
      acc_sym_d = sat_inc16(acc_sym_d, 1'b1);
      acc_err_d = sat_inc16(acc_err_d, mis);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_sym_q <= '0;
      acc_err_q <= '0;
      sym_cnt_q <= '0;
      sym_err_q <= '0;
    end else if (clk_en) begin
      acc_sym_q <= acc_sym_d;
      acc_err_q <= acc_err_d;
      if (hold) begin
        sym_cnt_q <= acc_sym_q;
        sym_err_q <= acc_err_q;
      end
    end
  end

  // The pulse is a single clk wide, so it is not frozen by clk_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_valid_q <= 1'b0;
    else        cnt_valid_q <= latch_now;
  end

`ifdef SYM_ERR_CHECKER_BIT_ERR_EN
  logic [1:0]  sym_diff;
  logic [1:0]  bit_errs;
  logic [16:0] acc_bit_q, acc_bit_d;
  logic [16:0] bit_err_q;
  logic [17:0] bit_sum;

  assign sym_diff = ref_sym ^ rx_sym;
  assign bit_errs = {1'b0, sym_diff[1]} + {1'b0, sym_diff[0]};

  always_comb begin
    acc_bit_d = latch_now ? 17'd0 : acc_bit_q;
    bit_sum   = {1'b0, acc_bit_d} + {16'd0, bit_errs};
    if (counting) acc_bit_d = bit_sum[17] ? 17'h1FFFF : bit_sum[16:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_bit_q <= '0;
      bit_err_q <= '0;
    end else if (clk_en) begin
      acc_bit_q <= acc_bit_d;
      if (hold) bit_err_q <= acc_bit_q;
    end
  end

  assign bit_err_cnt = bit_err_q;
`else
  assign bit_err_cnt = '0;
`endif

  assign delay_out   = delay_q;
  assign locked      = locked_q;
  assign sym_cnt     = sym_cnt_q;
  assign sym_err_cnt = sym_err_q;
  assign cnt_valid   = cnt_valid_q;

endmodule

// File: tb/tb_sym_err_checker.sv
// Bench for sym_err_checker: symbol-level reference model compared every cycle,
// plus literal checks for lock, unlock, window counts, async reset and saturation.
module tb_sym_err_checker;

  localparam int MAXD   = 63;
  localparam int LOCKN  = 32;
  localparam int UNL    = 16;
  localparam int SEARCH = 0;
  localparam int VERIFY = 1;
  localparam int LOCKED = 2;
`ifdef SYM_ERR_CHECKER_BIT_ERR_EN
  localparam bit BIT_EN = 1'b1;
`else
  localparam bit BIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  tx_sym = 2'd0;
  logic [1:0]  rx_sym = 2'd0;

  logic [5:0]  delay_out, s_delay;
  logic        locked, s_locked;
  logic [15:0] sym_err_cnt, s_sym_err;
  logic [15:0] sym_cnt, s_sym;
  logic [16:0] bit_err_cnt, s_bit;
  logic        cnt_valid, s_valid;

  sym_err_checker u_dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .hold(hold),
    .tx_sym(tx_sym), .rx_sym(rx_sym),
    .delay_out(delay_out), .locked(locked), .sym_err_cnt(sym_err_cnt),
    .sym_cnt(sym_cnt), .bit_err_cnt(bit_err_cnt), .cnt_valid(cnt_valid)
  );

  // Never loses lock, so long all-error runs can reach saturation.
  sym_err_checker #(.UNLOCK_ERRS(65)) u_sat (
    .clk(clk), .reset(reset), .clk_en(clk_en), .hold(hold),
    .tx_sym(tx_sym), .rx_sym(rx_sym),
    .delay_out(s_delay), .locked(s_locked), .sym_err_cnt(s_sym_err),
    .sym_cnt(s_sym), .bit_err_cnt(s_bit), .cnt_valid(s_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per clk edge.
  int  m_state, m_delay, m_run, m_blk, m_blkerr;
  int  acc_sym, acc_err, acc_bit, lat_sym, lat_err, lat_bit;
  bit  m_valid;
  int  hist[$];
  bit  chk_on = 1'b0;

  task automatic model_reset();
    m_state = SEARCH; m_delay = 0; m_run = 0; m_blk = 0; m_blkerr = 0;
    acc_sym = 0; acc_err = 0; acc_bit = 0;
    lat_sym = 0; lat_err = 0; lat_bit = 0;
    m_valid = 1'b0;
    hist = {};
    for (int i = 0; i < MAXD; i++) hist.push_back(0);
  endtask

  task automatic model_step(input bit en, input bit hl, input logic [1:0] tx, input logic [1:0] rx);
    int r, x, nb, mis, errs;
    m_valid = en && hl;
    if (!en) return;
    r    = (m_delay == 0) ? int'(tx) : hist[m_delay-1];
    x    = r ^ int'(rx);
    nb   = (x & 1) + ((x >> 1) & 1);
    mis  = (x != 0) ? 1 : 0;
    if (hl) begin
      lat_sym = acc_sym; lat_err = acc_err; lat_bit = acc_bit;
      acc_sym = 0; acc_err = 0; acc_bit = 0;
    end
    if (m_state == LOCKED) begin
      acc_sym = (acc_sym + 1   > 32'hFFFF)  ? 32'hFFFF  : acc_sym + 1;
      acc_err = (acc_err + mis > 32'hFFFF)  ? 32'hFFFF  : acc_err + mis;
      acc_bit = (acc_bit + nb  > 32'h1FFFF) ? 32'h1FFFF : acc_bit + nb;
    end
    case (m_state)
      SEARCH: if (mis == 0) begin m_state = VERIFY; m_run = 1; end
              else m_delay = (m_delay + 1) % (MAXD + 1);
      VERIFY: if (mis == 0) begin
                m_run++;
                if (m_run == LOCKN) begin m_state = LOCKED; m_run = 0; m_blk = 0; m_blkerr = 0; end
              end else begin
                m_state = SEARCH; m_run = 0; m_delay = (m_delay + 1) % (MAXD + 1);
              end
      default: begin
        errs = m_blkerr + mis;
        if (errs >= UNL) begin
          m_state = SEARCH; m_delay = (m_delay + 1) % (MAXD + 1); m_blk = 0; m_blkerr = 0;
        end else if (m_blk == 63) begin
          m_blk = 0; m_blkerr = 0;
        end else begin
          m_blk++; m_blkerr = errs;
        end
      end
    endcase
    hist.push_front(int'(tx));
    void'(hist.pop_back());
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("delay_out", delay_out, m_delay);
      check("locked", locked, m_state == LOCKED);
      check("cnt_valid", cnt_valid, m_valid);
      check("sym_cnt", sym_cnt, lat_sym);
      check("sym_err_cnt", sym_err_cnt, lat_err);
      check("bit_err_cnt", bit_err_cnt, BIT_EN ? lat_bit : 0);
    end
  end

  // Stimulus: LFSR x^6+x^5+1, symbol = low two state bits.
  logic [5:0] lfsr = 6'h01;
  int  cyc  = 0;
  bit  fast = 1'b0;

  task automatic cycle(input bit en, input bit hl, input logic [1:0] tx, input logic [1:0] rx);
    clk_en = en; hold = hl; tx_sym = tx; rx_sym = rx;
    @(posedge clk);
    if (reset) model_step(en, hl, tx, rx);
    if (en) lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    cyc++;
    #1;
  endtask

  // mode 0: rx = tx delayed 38; 1: inverted; 2: forced 2'b10.
  task automatic symbol(input bit hl, input int mode);
    logic [1:0] ex, rx;
    if (!fast && (cyc % 4 == 3)) cycle(1'b0, 1'b1, 2'($urandom), 2'($urandom));
    ex = 2'(hist[37]);
    case (mode)
      1:       rx = ~ex;
      2:       rx = 2'b10;
      default: rx = ex;
    endcase
    cycle(1'b1, hl, lfsr[1:0], rx);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int n;
    bit forced;
    model_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_delay", delay_out, 0);
    check("rst_locked", locked, 0);
    check("rst_valid", cnt_valid, 0);
    check("rst_sym_cnt", sym_cnt, 0);
    check("rst_err_cnt", sym_err_cnt, 0);
    check("rst_bit_cnt", bit_err_cnt, 0);
    chk_on = 1'b1;
    cycle(1'b1, 1'b1, 2'd3, 2'd1);
    cycle(1'b1, 1'b1, 2'd2, 2'd0);
    reset = 1'b1;

    // Acquire lock at delay 38.
    n = 0;
    while (m_state != LOCKED && n < 39 * 32 + 32) begin symbol(1'b0, 0); n++; end
    check("lock_locked", locked, 1);
    check("lock_delay", delay_out, 38);
    check("model_lock_delay", m_delay, 38);

    // Inverted rx; hold lands on the unlocking compare.
    n = 0;
    do begin symbol(n == 15, 1); n++; end while (locked && n < 64);
    check("unlock_errs", n, 16);
    check("unlock_delay", delay_out, 39);
    check("unlock_valid", cnt_valid, 1);
    check("unlock_sym_cnt", sym_cnt, 15);
    check("unlock_err_cnt", sym_err_cnt, 15);
    check("unlock_bit_cnt", bit_err_cnt, BIT_EN ? 30 : 0);

    // Relock, with hold on the locking compare.
    n = 0;
    while (m_state != LOCKED && n < 4000) begin
      symbol(m_state == VERIFY && m_run == LOCKN - 1, 0);
      n++;
    end
    check("relock_locked", locked, 1);
    check("relock_delay", delay_out, 38);
    check("relock_valid", cnt_valid, 1);
    check("relock_sym_cnt", sym_cnt, 1);
    check("relock_err_cnt", sym_err_cnt, 1);
    check("relock_bit_cnt", bit_err_cnt, BIT_EN ? 2 : 0);

    // 63-symbol windows, one ref=01 / rx=10 error each.
    for (int w = 0; w < 5; w++) begin
      forced = 1'b0;
      for (int k = 0; k < 63; k++) begin
        if (k >= 5 && !forced && hist[37] == 1) begin
          symbol(1'b0, 2);
          forced = 1'b1;
        end else begin
          symbol(k == 0, 0);
        end
        if (k == 0 && w > 0) begin
          check("win_valid", cnt_valid, 1);
          check("win_sym_cnt", sym_cnt, 63);
          check("win_err_cnt", sym_err_cnt, 1);
          check("win_bit_cnt", bit_err_cnt, BIT_EN ? 2 : 0);
        end
      end
    end
    check("win_still_locked", locked, 1);

    // Async reset between edges.
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("arst_locked", locked, 0);
    check("arst_delay", delay_out, 0);
    check("arst_sym_cnt", sym_cnt, 0);
    check("arst_err_cnt", sym_err_cnt, 0);
    check("arst_bit_cnt", bit_err_cnt, 0);
    check("arst_valid", cnt_valid, 0);
    #2 reset = 1'b1;

    n = 0;
    while (m_state != LOCKED && n < 39 * 32 + 32) begin symbol(1'b0, 0); n++; end
    check("lock2_locked", locked, 1);
    check("sat_pre_locked", s_locked, 1);

    // Saturation: 70000 all-error symbols without hold.
    fast = 1'b1;
    symbol(1'b1, 0);
    for (int i = 0; i < 70000; i++) symbol(1'b0, 1);
    symbol(1'b1, 0);
    check("sat_locked", s_locked, 1);
    check("sat_valid", s_valid, 1);
    check("sat_err_cnt", s_sym_err, 16'hFFFF);
    check("sat_sym_cnt", s_sym, 16'hFFFF);
    check("sat_bit_cnt", s_bit, BIT_EN ? 17'h1FFFF : 17'h0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
